// File: rtl/ecc_lockstep_pipe_chk.sv
// ecc_lockstep_pipe_chk: SECDED decode checker with two lockstep decode cores and a compare.
// Latency 2 cycles from in_vld&in_rdy to out_vld, 1 beat/clk; stages stall back to in_rdy when out_rdy=0.
// Optional build macro ECC_LOCKSTEP_ERR_INJ_EN adds inj_core1 to flip core 1 parity bit 0 (comparator self-test).
module ecc_lockstep_pipe_chk #(
  parameter int DATA_WIDTH   = 182,
  parameter int PARITY_WIDTH = 9,
  parameter int CNT_WIDTH    = 16,
  parameter int FAULT_THRESH = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    chk_en,
  input  logic                    bypass,
`ifdef ECC_LOCKSTEP_ERR_INJ_EN
  input  logic                    inj_core1,
`endif
  input  logic                    in_vld,
  output logic                    in_rdy,
  input  logic [DATA_WIDTH-1:0]   in_data,
  input  logic [PARITY_WIDTH-1:0] in_parity,
  output logic                    out_vld,
  input  logic                    out_rdy,
  output logic [DATA_WIDTH-1:0]   out_data,
  output logic                    out_sbit_err,
  output logic                    out_dbit_err,
  output logic                    out_fault,
  input  logic                    cnt_clr,
  output logic [CNT_WIDTH-1:0]    sbit_cnt,
  output logic [CNT_WIDTH-1:0]    dbit_cnt,
  output logic [CNT_WIDTH-1:0]    fault_cnt,
  output logic                    fault_sticky,
  output logic                    fault_alarm
);

  // Hamming check bits sit at power-of-two codeword positions; the top parity bit covers the whole word.
  localparam int HW   = PARITY_WIDTH - 1;
  localparam int NPOS = DATA_WIDTH + HW;
  localparam logic [CNT_WIDTH-1:0] THRESH = CNT_WIDTH'(FAULT_THRESH);

  typedef struct packed {
    logic                  sbe;
    logic                  dbe;
    logic [DATA_WIDTH-1:0] mask;
  } dec_t;

  // Codeword position (1-based) of data bit idx, skipping the power-of-two check positions.
  function automatic int dpos(input int idx);
    int pos;
    pos = idx + 1;
    for (int k = 0; k < HW; k++) begin
      if (pos >= (1 << k)) pos = pos + 1;
    end
    return pos;
  endfunction

  // One decode core: syndrome, overall parity, classification and correction mask.
  function automatic dec_t decode(input logic [DATA_WIDTH-1:0]   d,
                                  input logic [PARITY_WIDTH-1:0] p,
                                  input logic                    byp);
    dec_t r;
    int   syn;
    logic odd;
    r   = '0;
    syn = int'(p[HW-1:0]);
    for (int i = 0; i < DATA_WIDTH; i++) begin
      if (d[i]) syn = syn ^ dpos(i);
    end
    odd = ^{d, p};
    if (!byp) begin
      if (odd) begin
        // Odd weight: single error, unless the syndrome points past the end of the codeword.
        if (syn > NPOS) begin
          r.dbe = 1'b1;
        end else begin
          r.sbe = 1'b1;
          for (int i = 0; i < DATA_WIDTH; i++) r.mask[i] = (syn == dpos(i));
        end
      end else if (syn != 0) begin
        r.dbe = 1'b1;
      end
    end
    return r;
  endfunction

  logic                    rdy_en_q, rdy_en_d;
  logic                    s1_vld_q, s1_vld_d;
  logic [DATA_WIDTH-1:0]   s1_data_q, s1_data_d;
  logic [PARITY_WIDTH-1:0] s1_parity_q, s1_parity_d;
  logic                    s2_vld_q, s2_vld_d;
  logic [DATA_WIDTH-1:0]   s2_data_q, s2_data_d;
  logic                    s2_sbe_q, s2_sbe_d;
  logic                    s2_dbe_q, s2_dbe_d;
  logic                    s2_fault_q, s2_fault_d;
  logic [CNT_WIDTH-1:0]    sbit_cnt_q, sbit_cnt_d;
  logic [CNT_WIDTH-1:0]    dbit_cnt_q, dbit_cnt_d;
  logic [CNT_WIDTH-1:0]    fault_cnt_q, fault_cnt_d;
  logic                    sticky_q, sticky_d;
  logic                    alarm_q, alarm_d;

  logic                    s1_adv, s2_adv, out_hs;
  logic [PARITY_WIDTH-1:0] core1_parity;
  dec_t                    dec0, dec1;
  logic                    fault;

  // Stage handshakes; in_rdy held low for the first cycle after reset release.
  always_comb begin
    s2_adv = ~s2_vld_q | out_rdy;
    s1_adv = ~s1_vld_q | s2_adv;
    in_rdy = rdy_en_q & s1_adv;
    out_hs = s2_vld_q & out_rdy;
  end

  // Core 1 parity input, optionally corrupted to prove the comparator works.
  always_comb begin
    core1_parity = s1_parity_q;
`ifdef ECC_LOCKSTEP_ERR_INJ_EN
    core1_parity[0] = s1_parity_q[0] ^ inj_core1;
`endif
  end

  // Decode core 0 (drives data and flags).
  always_comb dec0 = decode(s1_data_q, s1_parity_q, bypass);

  // Decode core 1 (checker only).
  always_comb dec1 = decode(s1_data_q, core1_parity, bypass);

  // Lockstep compare of flags and correction masks.
  always_comb fault = chk_en & (dec0 != dec1);

  // Pipeline stage next-state: S1 captures input, S2 captures decoded result.
  always_comb begin
    rdy_en_d    = 1'b1;
    s1_vld_d    = s1_vld_q;
    s1_data_d   = s1_data_q;
    s1_parity_d = s1_parity_q;
    s2_vld_d    = s2_vld_q;
    s2_data_d   = s2_data_q;
    s2_sbe_d    = s2_sbe_q;
    s2_dbe_d    = s2_dbe_q;
    s2_fault_d  = s2_fault_q;
    if (s1_adv) s1_vld_d = in_vld & rdy_en_q;
    if (in_vld & in_rdy) begin
      s1_data_d   = in_data;
      s1_parity_d = in_parity;
    end
    if (s2_adv) s2_vld_d = s1_vld_q;
    if (s2_adv & s1_vld_q) begin
      // A disagreeing core means the correction cannot be trusted: pass stored data untouched.
      s2_data_d  = fault ? s1_data_q : (s1_data_q ^ dec0.mask);
      s2_sbe_d   = dec0.sbe;
      s2_dbe_d   = dec0.dbe;
      s2_fault_d = fault;
    end
  end

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] c);
    return (c == '1) ? c : c + CNT_WIDTH'(1);
  endfunction

  // Event counters and status: count on output handshake only, clear wins over increment.
  always_comb begin
    sbit_cnt_d  = sbit_cnt_q;
    dbit_cnt_d  = dbit_cnt_q;
    fault_cnt_d = fault_cnt_q;
    sticky_d    = sticky_q;
    if (out_hs & s2_sbe_q)   sbit_cnt_d  = sat_inc(sbit_cnt_q);
    if (out_hs & s2_dbe_q)   dbit_cnt_d  = sat_inc(dbit_cnt_q);
    if (out_hs & s2_fault_q) begin
      fault_cnt_d = sat_inc(fault_cnt_q);
      sticky_d    = 1'b1;
    end
    if (cnt_clr) begin
      sbit_cnt_d  = '0;
      dbit_cnt_d  = '0;
      fault_cnt_d = '0;
      sticky_d    = 1'b0;
    end
    alarm_d = ~cnt_clr & (fault_cnt_d >= THRESH);
  end

  // State registers; async reset drops any in-flight beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdy_en_q    <= 1'b0;
      s1_vld_q    <= 1'b0;
      s1_data_q   <= '0;
      s1_parity_q <= '0;
      s2_vld_q    <= 1'b0;
      s2_data_q   <= '0;
      s2_sbe_q    <= 1'b0;
      s2_dbe_q    <= 1'b0;
      s2_fault_q  <= 1'b0;
      sbit_cnt_q  <= '0;
      dbit_cnt_q  <= '0;
      fault_cnt_q <= '0;
      sticky_q    <= 1'b0;
      alarm_q     <= 1'b0;
    end else begin
      rdy_en_q    <= rdy_en_d;
      s1_vld_q    <= s1_vld_d;
      s1_data_q   <= s1_data_d;
      s1_parity_q <= s1_parity_d;
      s2_vld_q    <= s2_vld_d;
      s2_data_q   <= s2_data_d;
      s2_sbe_q    <= s2_sbe_d;
      s2_dbe_q    <= s2_dbe_d;
      s2_fault_q  <= s2_fault_d;
      sbit_cnt_q  <= sbit_cnt_d;
      dbit_cnt_q  <= dbit_cnt_d;
      fault_cnt_q <= fault_cnt_d;
      sticky_q    <= sticky_d;
      alarm_q     <= alarm_d;
    end
  end

  assign out_vld      = s2_vld_q;
  assign out_data     = s2_data_q;
  assign out_sbit_err = s2_sbe_q;
  assign out_dbit_err = s2_dbe_q;
  assign out_fault    = s2_fault_q;
  assign sbit_cnt     = sbit_cnt_q;
  assign dbit_cnt     = dbit_cnt_q;
  assign fault_cnt    = fault_cnt_q;
  assign fault_sticky = sticky_q;
  assign fault_alarm  = alarm_q;

endmodule

// File: tb/tb_ecc_lockstep_pipe_chk.sv
// Directed bench for ecc_lockstep_pipe_chk: vector table plus stall, clear, injection and reset sequences.
// A second instance with CNT_WIDTH=2 shares the stimulus to exercise counter saturation.
module tb_ecc_lockstep_pipe_chk;
  localparam int DW = 182;
  localparam int PW = 9;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          chk_en, bypass, in_vld, out_rdy, cnt_clr;
  logic [DW-1:0] in_data;
  logic [PW-1:0] in_parity;
`ifdef ECC_LOCKSTEP_ERR_INJ_EN
  logic          inj_core1;
`endif
  logic          in_rdy, out_vld, out_sbit_err, out_dbit_err, out_fault, fault_sticky, fault_alarm;
  logic [DW-1:0] out_data;
  logic [15:0]   sbit_cnt, dbit_cnt, fault_cnt;
  logic          in_rdy2, out_vld2, out_sbit_err2, out_dbit_err2, out_fault2, fault_sticky2, fault_alarm2;
  logic [DW-1:0] out_data2;
  logic [1:0]    sbit_cnt2, dbit_cnt2, fault_cnt2;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  ecc_lockstep_pipe_chk u_dut (
    .clk(clk), .rst_n(rst_n), .chk_en(chk_en), .bypass(bypass),
`ifdef ECC_LOCKSTEP_ERR_INJ_EN
    .inj_core1(inj_core1),
`endif
    .in_vld(in_vld), .in_rdy(in_rdy), .in_data(in_data), .in_parity(in_parity),
    .out_vld(out_vld), .out_rdy(out_rdy), .out_data(out_data),
    .out_sbit_err(out_sbit_err), .out_dbit_err(out_dbit_err), .out_fault(out_fault),
    .cnt_clr(cnt_clr), .sbit_cnt(sbit_cnt), .dbit_cnt(dbit_cnt), .fault_cnt(fault_cnt),
    .fault_sticky(fault_sticky), .fault_alarm(fault_alarm)
  );

  ecc_lockstep_pipe_chk #(.CNT_WIDTH(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .chk_en(chk_en), .bypass(bypass),
`ifdef ECC_LOCKSTEP_ERR_INJ_EN
    .inj_core1(inj_core1),
`endif
    .in_vld(in_vld), .in_rdy(in_rdy2), .in_data(in_data), .in_parity(in_parity),
    .out_vld(out_vld2), .out_rdy(out_rdy), .out_data(out_data2),
    .out_sbit_err(out_sbit_err2), .out_dbit_err(out_dbit_err2), .out_fault(out_fault2),
    .cnt_clr(cnt_clr), .sbit_cnt(sbit_cnt2), .dbit_cnt(dbit_cnt2), .fault_cnt(fault_cnt2),
    .fault_sticky(fault_sticky2), .fault_alarm(fault_alarm2)
  );

  typedef struct {
    logic [DW-1:0] data;
    int            fa;
    int            fb;
    int            pf;
    bit            byp;
    logic [DW-1:0] exp_data;
    bit            exp_sbe;
    bit            exp_dbe;
    string         name;
  } vec_t;

  vec_t vt[10];

  // Reference SECDED encoder: Hamming positions 1..N with check bits at powers of two, plus overall parity.
  function automatic logic [PW-1:0] enc(input logic [DW-1:0] d);
    int            s;
    int            j;
    logic [PW-1:0] p;
    s = 0;
    j = 0;
    for (int pos = 1; pos <= DW + PW - 1; pos++) begin
      if ((pos & (pos - 1)) != 0) begin
        if (d[j]) s = s ^ pos;
        j++;
      end
    end
    p[PW-2:0] = s[PW-2:0];
    p[PW-1]   = (^d) ^ (^s[PW-2:0]);
    return p;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0b, expected %0b", nm, act, exp);
    end
  endtask

  task automatic chkd(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic chkn(input string nm, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  // Present one beat with out_rdy=1 and check the 2-cycle latency; returns with the beat on the output.
  task automatic apply_beat(input logic [DW-1:0] d, input logic [PW-1:0] p);
    int w;
    w = 0;
    in_data   = d;
    in_parity = p;
    in_vld    = 1'b1;
    while (!in_rdy && w < 20) begin
      tick();
      w++;
    end
    chk1("accept_rdy", in_rdy, 1'b1);
    tick();
    in_vld = 1'b0;
    chk1("lat_cycle1_vld", out_vld, 1'b0);
    tick();
    chk1("lat_cycle2_vld", out_vld, 1'b1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish by 100000 ns, expected finish");
    $fatal(1);
  end

  initial begin
    logic [DW-1:0] d;
    logic [PW-1:0] p;
    logic [DW-1:0] da, db, dc;
    int            exp_s, exp_d;

    vt[0] = '{182'h1234, -1, -1, -1, 1'b0, 182'h1234, 1'b0, 1'b0, "clean"};
    vt[1] = '{182'h1234,  5, -1, -1, 1'b0, 182'h1234, 1'b1, 1'b0, "sbe_b5"};
    vt[2] = '{182'h1234,  5, 77, -1, 1'b0, 182'h1234 ^ (182'h1 << 5) ^ (182'h1 << 77), 1'b0, 1'b1, "dbe_b5_b77"};
    vt[3] = '{{182{1'b1}}, 181, -1, -1, 1'b0, {182{1'b1}}, 1'b1, 1'b0, "sbe_b181_ones"};
    vt[4] = '{182'h0,     0, -1, -1, 1'b0, 182'h0, 1'b1, 1'b0, "sbe_b0_zero"};
    vt[5] = '{182'hDEADBEEF, -1, -1, 0, 1'b0, 182'hDEADBEEF, 1'b1, 1'b0, "sbe_chk0"};
    vt[6] = '{182'hCAFE, -1, -1, 8, 1'b0, 182'hCAFE, 1'b1, 1'b0, "sbe_overall_par"};
    vt[7] = '{182'h0,     0, -1, 3, 1'b0, 182'h1, 1'b0, 1'b1, "dbe_b0_chk3"};
    vt[8] = '{182'h1234, 100, 101, -1, 1'b0, 182'h1234 ^ (182'h1 << 100) ^ (182'h1 << 101), 1'b0, 1'b1, "dbe_b100_b101"};
    vt[9] = '{182'h1234,  5, -1, -1, 1'b1, 182'h1234 ^ (182'h1 << 5), 1'b0, 1'b0, "bypass_b5"};

    chk_en = 1'b1; bypass = 1'b0; in_vld = 1'b0; out_rdy = 1'b1; cnt_clr = 1'b0;
    in_data = '0; in_parity = '0;
`ifdef ECC_LOCKSTEP_ERR_INJ_EN
    inj_core1 = 1'b0;
`endif

    // Reset state
    #2;
    chk1("rst_in_rdy", in_rdy, 1'b0);
    chk1("rst_out_vld", out_vld, 1'b0);
    chk1("rst_out_flags", out_sbit_err | out_dbit_err | out_fault, 1'b0);
    chkd("rst_out_data", out_data, '0);
    chkn("rst_sbit_cnt", int'(sbit_cnt), 0);
    chkn("rst_fault_cnt", int'(fault_cnt), 0);
    chk1("rst_sticky", fault_sticky, 1'b0);
    chk1("rst_alarm", fault_alarm, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk1("rel_in_rdy_before_edge", in_rdy, 1'b0);
    tick();
    chk1("rel_in_rdy_after_edge", in_rdy, 1'b1);

    // Vector table, one beat at a time with out_rdy=1
    exp_s = 0;
    exp_d = 0;
    for (int v = 0; v < 10; v++) begin
      d = vt[v].data;
      p = enc(d);
      if (vt[v].fa >= 0) d[vt[v].fa] = ~d[vt[v].fa];
      if (vt[v].fb >= 0) d[vt[v].fb] = ~d[vt[v].fb];
      if (vt[v].pf >= 0) p[vt[v].pf] = ~p[vt[v].pf];
      bypass = vt[v].byp;
      apply_beat(d, p);
      chkd($sformatf("%s_data", vt[v].name), out_data, vt[v].exp_data);
      chk1($sformatf("%s_sbe", vt[v].name), out_sbit_err, vt[v].exp_sbe);
      chk1($sformatf("%s_dbe", vt[v].name), out_dbit_err, vt[v].exp_dbe);
      chk1($sformatf("%s_fault", vt[v].name), out_fault, 1'b0);
      if (vt[v].exp_sbe) exp_s++;
      if (vt[v].exp_dbe) exp_d++;
      tick();
      bypass = 1'b0;
      chk1($sformatf("%s_vld_drop", vt[v].name), out_vld, 1'b0);
      chkn($sformatf("%s_sbit_cnt", vt[v].name), int'(sbit_cnt), exp_s);
      chkn($sformatf("%s_dbit_cnt", vt[v].name), int'(dbit_cnt), exp_d);
      chkn($sformatf("%s_sbit_cnt_w2", vt[v].name), int'(sbit_cnt2), (exp_s > 3) ? 3 : exp_s);
    end
    chkn("sat_sbit_cnt_w2", int'(sbit_cnt2), 3);
    chkn("no_fault_cnt", int'(fault_cnt), 0);
    chk1("no_fault_sticky", fault_sticky, 1'b0);

    // Counter clear
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    chkn("clr_sbit_cnt", int'(sbit_cnt), 0);
    chkn("clr_dbit_cnt", int'(dbit_cnt), 0);
    chkn("clr_sbit_cnt_w2", int'(sbit_cnt2), 0);

    // Stall: three beats against out_rdy=0, middle one carries an SBE
    da = 182'h111;
    db = 182'h222;
    dc = 182'h333;
    out_rdy = 1'b0;
    in_data = da; in_parity = enc(da); in_vld = 1'b1;
    chk1("stall_rdy_a", in_rdy, 1'b1);
    tick();
    in_data = db; in_parity = enc(db); in_data[3] = ~in_data[3];
    chk1("stall_rdy_b", in_rdy, 1'b1);
    tick();
    in_data = dc; in_parity = enc(dc);
    chk1("stall_rdy_full", in_rdy, 1'b0);
    chk1("stall_out_vld", out_vld, 1'b1);
    for (int c = 0; c < 10; c++) begin
      tick();
      chkd("stall_hold_data", out_data, da);
      chk1("stall_hold_rdy", in_rdy, 1'b0);
    end
    out_rdy = 1'b1;
    #1;
    chk1("stall_release_rdy", in_rdy, 1'b1);
    tick();
    in_vld = 1'b0;
    chkd("stall_out_b", out_data, db);
    chk1("stall_out_b_sbe", out_sbit_err, 1'b1);
    chkn("stall_cnt_before_b", int'(sbit_cnt), 0);
    tick();
    chkd("stall_out_c", out_data, dc);
    chkn("stall_cnt_after_b", int'(sbit_cnt), 1);
    tick();
    chk1("stall_drain_vld", out_vld, 1'b0);
    chkn("stall_cnt_once", int'(sbit_cnt), 1);
    chkn("stall_cnt_once_w2", int'(sbit_cnt2), 1);

    // Clear in the same cycle as an SBE handshake drops the increment
    d = 182'h5555;
    p = enc(d);
    d[9] = ~d[9];
    apply_beat(d, p);
    chk1("clrhs_sbe", out_sbit_err, 1'b1);
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    chkn("clrhs_sbit_cnt", int'(sbit_cnt), 0);
    chkn("clrhs_sbit_cnt_w2", int'(sbit_cnt2), 0);

`ifdef ECC_LOCKSTEP_ERR_INJ_EN
    // Injected core 1 mismatch: raw data out, fault flagged and counted
    d = 182'h1234;
    p = enc(d);
    d[5] = ~d[5];
    inj_core1 = 1'b1;
    chk_en = 1'b1;
    apply_beat(d, p);
    chk1("inj_fault", out_fault, 1'b1);
    chkd("inj_raw_data", out_data, 182'h1234 ^ (182'h1 << 5));
    chk1("inj_sbe_core0", out_sbit_err, 1'b1);
    tick();
    chk1("inj_sticky", fault_sticky, 1'b1);
    chkn("inj_fault_cnt", int'(fault_cnt), 1);
    chk1("inj_alarm", fault_alarm, 1'b1);
    chk_en = 1'b0;
    apply_beat(d, p);
    chk1("inj_chk_off_fault", out_fault, 1'b0);
    chkd("inj_chk_off_data", out_data, 182'h1234);
    tick();
    chkn("inj_chk_off_fault_cnt", int'(fault_cnt), 1);
    inj_core1 = 1'b0;
    chk_en = 1'b1;
`endif

    // Async reset mid-transfer: nonzero counter first, then reset with a beat on the output
    d = 182'h77;
    p = enc(d);
    d[2] = ~d[2];
    apply_beat(d, p);
    tick();
    chk1("prerst_sbit_nonzero", sbit_cnt != 16'd0, 1'b1);
    apply_beat(182'h99, enc(182'h99));
    #2;
    rst_n = 1'b0;
    #1;
    chk1("arst_out_vld", out_vld, 1'b0);
    chk1("arst_in_rdy", in_rdy, 1'b0);
    chkn("arst_sbit_cnt", int'(sbit_cnt), 0);
    chk1("arst_sticky", fault_sticky, 1'b0);
    #10;
    rst_n = 1'b1;
    tick();
    chk1("arst_rel_rdy", in_rdy, 1'b1);
    apply_beat(182'hABC, enc(182'hABC));
    chkd("arst_recover_data", out_data, 182'hABC);
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
